// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath: default widths and the
// context-copy FSM state encoding.
package cpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREG_DEF   = 4;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_REST = 2'd2
    } ctx_state_e;

endpackage

// File: rtl/ctx_stack.sv
// Context stack storage: one register bank per slot, addressed {slot, idx},
// synchronous write and asynchronous read on a single shared address.
module ctx_stack #(
    parameter int  DATA_W = 8,
    parameter int  NREG   = 4,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(NREG),
    localparam int SLW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [SLW-1:0]    slot_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int ADW = SLW + AW;

    logic [DATA_W-1:0] mem_q [2**ADW];
    logic [ADW-1:0]    addr;

    assign addr = {slot_i, idx_i};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr];

endmodule

// File: rtl/regfile_ctx.sv
// General-purpose register file with two bypassed read ports, lock/hold,
// and a serial-copy FSM that saves/restores the whole bank to a context stack.
module regfile_ctx
    import cpu_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  NREG   = NREG_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int AW     = $clog2(NREG),
    localparam int SPW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lock,
    input  logic [AW-1:0]          aa,
    input  logic [AW-1:0]          ab,
    output logic [DATA_W-1:0]      ra,
    output logic [DATA_W-1:0]      rb,
    input  logic                   wr,
    input  logic [AW-1:0]          ad,
    input  logic [DATA_W-1:0]      rd,
    input  logic                   save_req,
    input  logic                   rest_req,
    output logic                   busy,
    output logic                   done,
    output logic                   ctx_ovf,
    output logic                   ctx_unf,
    output logic [SPW-1:0]         sp,
    output logic [NREG*DATA_W-1:0] regs_flat
);

    localparam int             SLW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
    localparam logic [AW-1:0]  IDX_LAST = AW'(NREG - 1);

    ctx_state_e state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [SPW-1:0] sp_q, sp_d, sp_m1;
    logic [SLW-1:0] slot_sel;
    logic done_q, done_d, ovf_q, ovf_d, unf_q, unf_d;
    logic stk_we, busy_w;

    logic [NREG-1:0][DATA_W-1:0] regs_w;
    logic [DATA_W-1:0] ra_hold_q, rb_hold_q, ra_live, rb_live, stk_rdata;

    assign busy_w = (state_q != ST_IDLE);
    assign sp_m1  = sp_q - SPW'(1);
    // Saves fill slot sp; restores drain slot sp-1.
    assign slot_sel = (state_q == ST_REST) ? SLW'(sp_m1) : SLW'(sp_q);

    ctx_stack #(
        .DATA_W(DATA_W),
        .NREG  (NREG),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk    (clk),
        .we_i   (stk_we),
        .slot_i (slot_sel),
        .idx_i  (idx_q),
        .wdata_i(regs_w[idx_q]),
        .rdata_o(stk_rdata)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sp_d    = sp_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        stk_we  = 1'b0;
        if (!lock) begin
            case (state_q)
                ST_IDLE: begin
                    if (save_req) begin
                        if (sp_q == SP_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            state_d = ST_SAVE;
                            idx_d   = '0;
                        end
                    end else if (rest_req) begin
                        if (sp_q == '0) begin
                            unf_d = 1'b1;
                        end else begin
                            state_d = ST_REST;
                            idx_d   = '0;
                        end
                    end
                end
                ST_SAVE: begin
                    stk_we = 1'b1;
                    idx_d  = idx_q + AW'(1);
                    if (idx_q == IDX_LAST) begin
                        sp_d    = sp_q + SPW'(1);
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                ST_REST: begin
                    idx_d = idx_q + AW'(1);
                    if (idx_q == IDX_LAST) begin
                        sp_d    = sp_m1;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Each register picks its write source: port write in IDLE, stack copy in REST.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic              wen;
        logic [DATA_W-1:0] wval;
        logic [DATA_W-1:0] val_q;

        always_comb begin
            wen  = 1'b0;
            wval = rd;
            if (!lock) begin
                if (state_q == ST_IDLE && wr && ad == AW'(gi)) begin
                    wen  = 1'b1;
                    wval = rd;
                end else if (state_q == ST_REST && idx_q == AW'(gi)) begin
                    wen  = 1'b1;
                    wval = stk_rdata;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                val_q <= '0;
            end else if (wen) begin
                val_q <= wval;
            end
        end

        assign regs_w[gi] = val_q;
    end

    assign ra_live = (wr && ad == aa && !busy_w) ? rd : regs_w[aa];
    assign rb_live = (wr && ad == ab && !busy_w) ? rd : regs_w[ab];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sp_q      <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ra_hold_q <= '0;
            rb_hold_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (!lock) begin
                ra_hold_q <= ra_live;
                rb_hold_q <= rb_live;
            end
        end
    end

    assign ra        = lock ? ra_hold_q : ra_live;
    assign rb        = lock ? rb_hold_q : rb_live;
    assign busy      = busy_w;
    assign done      = done_q;
    assign ctx_ovf   = ovf_q;
    assign ctx_unf   = unf_q;
    assign sp        = sp_q;
    assign regs_flat = regs_w;

endmodule
